// File: rtl/mux_4to1.sv
// Parameterised 4-to-1 word multiplexer with a combinational output and an
// enable-gated, synchronously reset registered copy.
module mux_4to1 #(
    parameter  int INPUT_BIT_LENGTH = 1,
    localparam int W = (INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [1:0]   sel,
    input  logic         en,
    output logic [W-1:0] z,
    output logic [W-1:0] z_q
);

    always_comb begin
        // NOTE: z gets a default before the case and every branch drives it, so no latch is inferred; the X default lets an unknown sel propagate instead of silently picking an input.
        z = 'x;
        case (sel)
            2'b00:   z = a;
            2'b01:   z = b;
            2'b10:   z = c;
            2'b11:   z = d;
            default: z = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge, never asynchronously.
        if (rst) begin
            z_q <= '0;
        end else if (en) begin
            z_q <= z;
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 at widths 1, 8 and 0 (elaborated as 1),
// with a scoreboard queue of expected values popped at each observation point.
module tb_mux_4to1;

    logic clk;
    logic rst;

    logic       a1, b1, c1, d1, en1, z1, zq1;
    logic [1:0] sel1;
    logic [7:0] a8, b8, c8, d8, z8, zq8;
    logic [1:0] sel8;
    logic       en8;
    logic       a0, b0, c0, d0, en0, z0, zq0;
    logic [1:0] sel0;

    int tests;
    int fails;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    mux_4to1 #(.INPUT_BIT_LENGTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
        .sel(sel1), .en(en1), .z(z1), .z_q(zq1)
    );

    mux_4to1 #(.INPUT_BIT_LENGTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8),
        .sel(sel8), .en(en8), .z(z8), .z_q(zq8)
    );

    mux_4to1 #(.INPUT_BIT_LENGTH(0)) u_w0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .c(c0), .d(d0),
        .sel(sel0), .en(en0), .z(z0), .z_q(zq0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: index a small table of the four inputs by sel.
    function automatic logic [7:0] model(input logic [1:0] s, input logic [7:0] ia,
                                         input logic [7:0] ib, input logic [7:0] ic,
                                         input logic [7:0] id);
        logic [7:0] words [4];
        words[0] = ia;
        words[1] = ib;
        words[2] = ic;
        words[3] = id;
        return words[s];
    endfunction

    task automatic push(input string tag, input logic [7:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [7:0] obs);
        string      tag;
        logic [7:0] exp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        {a1, b1, c1, d1, en1} = '0;
        sel1 = 2'b00;
        {a8, b8, c8, d8} = '0;
        sel8 = 2'b00;
        en8  = 1'b0;
        {a0, b0, c0, d0, en0} = '0;
        sel0 = 2'b00;

        // Reset state and the all-zero starting point of the select walk.
        push("reset_zq_w1", 8'h00);
        push("reset_zq_w8", 8'h00);
        push("reset_zq_w0", 8'h00);
        push("idle_z_w1", 8'h00);
        tick();
        check({7'd0, zq1});
        check(zq8);
        check(zq0);
        check({7'd0, z1});
        rst = 1'b0;

        // Select walk at width 1 and at width 0 (elaborated as width 1).
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b1;
        a0 = 1'b1; b0 = 1'b0; c0 = 1'b0; d0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel1 = 2'(i);
            sel0 = 2'(i);
            push($sformatf("walk_w1_sel%0d", i), model(sel1, {7'd0, a1}, {7'd0, b1}, {7'd0, c1}, {7'd0, d1}));
            push($sformatf("walk_w0_sel%0d", i), model(sel0, {7'd0, a0}, {7'd0, b0}, {7'd0, c0}, {7'd0, d0}));
            #10;
            check({7'd0, z1});
            check({7'd0, z0});
        end

        // Wide data: distinct bit patterns expose any crosstalk or mis-steering.
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sel8 = 2'(i);
            push($sformatf("wide_sel%0d", i), model(sel8, a8, b8, c8, d8));
            #1;
            check(z8);
        end

        // Registered path: sel and data change every cycle, z_q lags z by one edge.
        en8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel8 = 2'((i * 3) % 4);
            a8   = 8'(8'h11 * i);
            d8   = ~8'(8'h11 * i);
            push($sformatf("reg_z_step%0d", i), model(sel8, a8, b8, c8, d8));
            #1;
            check(z8);
            push($sformatf("reg_zq_step%0d", i), model(sel8, a8, b8, c8, d8));
            tick();
            check(zq8);
        end

        // Enable hold: load 1, drop en, steer z to 0 and confirm z_q holds.
        sel1 = 2'b00; a1 = 1'b1; en1 = 1'b1;
        push("hold_load_zq", 8'h01);
        tick();
        check({7'd0, zq1});
        en1 = 1'b0; sel1 = 2'b01; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("hold_zq_cyc%0d", i), 8'h01);
            push($sformatf("hold_z_cyc%0d", i), 8'h00);
            tick();
            check({7'd0, zq1});
            check({7'd0, z1});
        end

        // Reset priority over enable; z keeps following inputs during reset.
        sel1 = 2'b00; a1 = 1'b1; en1 = 1'b1;
        sel8 = 2'b10; en8 = 1'b1;
        rst  = 1'b1;
        push("rst_prio_zq_w1", 8'h00);
        push("rst_prio_z_w1", 8'h01);
        push("rst_prio_zq_w8", 8'h00);
        push("rst_prio_z_w8", 8'hFF);
        tick();
        check({7'd0, zq1});
        check({7'd0, z1});
        check(zq8);
        check(z8);
        rst = 1'b0;
        push("post_rst_zq_w1", 8'h01);
        push("post_rst_zq_w8", 8'hFF);
        tick();
        check({7'd0, zq1});
        check(zq8);

        // Registered path at width 0 after a reset.
        en0 = 1'b1; sel0 = 2'b11;
        push("w0_reg_zq", 8'h01);
        tick();
        check({7'd0, zq0});

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
